// File: rtl/bf_pkg.sv
// Shared constants, state encoding and the digit-to-ASCII helper for the
// brute-force candidate scheduler.
package bf_pkg;

  localparam int         ALPHA_SIZE    = 26;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [5:0] DIGIT_MAX     = 6'(ALPHA_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    FOUND     = 2'd2,
    EXHAUSTED = 2'd3
  } state_e;

  function automatic logic [7:0] digit_to_ascii(input logic [4:0] digit, input logic upper);
    logic [7:0] base;
    if (upper) begin
      base = ASCII_UPPER_A;
    end else begin
      base = ASCII_LOWER_A;
    end
    return base + {3'b000, digit};
  endfunction

endpackage

// File: rtl/bf_letter_digit.sv
// One mod-26 odometer digit. The load value doubles as the wrap value, so
// digit 0 wraps back to its start offset while the others wrap to zero.
module bf_letter_digit
  import bf_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_load,
  input  logic [4:0] i_load_val,
  input  logic [2:0] i_step,
  input  logic       i_carry_in,
  output logic [4:0] o_digit,
  output logic       o_carry_out
);

  logic [4:0] r_digit;
  logic [4:0] r_base;
  logic [2:0] r_step;
  logic [5:0] w_sum;
  logic       w_wrap;

  assign w_sum       = {1'b0, r_digit} + {3'b000, r_step};
  assign w_wrap      = (w_sum > DIGIT_MAX);
  assign o_carry_out = i_carry_in & w_wrap;
  assign o_digit     = r_digit;

  // Digit value plus the wrap base and step captured at search start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_digit <= 5'd0;
      r_base  <= 5'd0;
      r_step  <= 3'd1;
    end else if (i_load) begin
      r_digit <= i_load_val;
      r_base  <= i_load_val;
      r_step  <= i_step;
    end else if (i_carry_in) begin
      r_digit <= w_wrap ? r_base : w_sum[4:0];
    end
  end

endmodule

// File: rtl/brute_force_scheduler.sv
// Odometer-style candidate generator with valid/ready output and target match.
// Optional macro BRUTE_FORCE_UPPER_EN adds an upper_case input latched on start.
module brute_force_scheduler
  import bf_pkg::*;
#(
  parameter int NUM_CHARS = 4,
  parameter int ATTEMPT_W = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [8*NUM_CHARS-1:0] target,
  input  logic [4:0]             start_offset,
  input  logic [2:0]             stride,
`ifdef BRUTE_FORCE_UPPER_EN
  input  logic                   upper_case,
`endif
  output logic                   cand_valid,
  input  logic                   cand_ready,
  output logic [8*NUM_CHARS-1:0] candidate,
  output logic                   busy,
  output logic                   found,
  output logic                   done,
  output logic [8*NUM_CHARS-1:0] found_word,
  output logic [ATTEMPT_W-1:0]   attempts
);

  state_e                 r_state;
  logic                   r_cand_valid;
  logic                   r_busy;
  logic                   r_found;
  logic                   r_done;
  logic [8*NUM_CHARS-1:0] r_found_word;
  logic [8*NUM_CHARS-1:0] r_target;
  logic [ATTEMPT_W-1:0]   r_attempts;

  logic [4:0]             w_digit [NUM_CHARS];
  logic [NUM_CHARS:0]     w_carry;
  logic [8*NUM_CHARS-1:0] w_candidate;
  logic [2:0]             w_stride_eff;
  logic                   w_xfer;
  logic                   w_match;
  logic                   w_advance;
  logic                   w_exhaust;
  logic                   w_start_ok;
  logic                   w_bad_offset;
  logic                   w_load;
  logic                   w_upper;
  logic [ATTEMPT_W-1:0]   w_attempts_nxt;

`ifdef BRUTE_FORCE_UPPER_EN
  logic r_upper;

  // Letter case selection captured with each accepted start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_upper <= 1'b0;
    end else if (w_load) begin
      r_upper <= upper_case;
    end
  end

  assign w_upper = r_upper;
`else
  assign w_upper = 1'b0;
`endif

  assign w_stride_eff = (stride == 3'd0) ? 3'd1 : stride;
  assign w_xfer       = r_cand_valid & cand_ready;
  assign w_match      = (w_candidate == r_target);
  // abort wins over a same-cycle transfer: the odometer must not move
  assign w_advance    = w_xfer & ~abort & ~w_match;
  assign w_exhaust    = w_carry[NUM_CHARS];
  assign w_start_ok   = start & ~abort & (r_state != RUN);
  assign w_bad_offset = ({1'b0, start_offset} > DIGIT_MAX);
  assign w_load       = w_start_ok & ~w_bad_offset;
  assign w_carry[0]   = w_advance;

  assign w_attempts_nxt = (r_attempts == {ATTEMPT_W{1'b1}}) ? r_attempts
                        : r_attempts + {{(ATTEMPT_W-1){1'b0}}, 1'b1};

  genvar g;
  for (g = 0; g < NUM_CHARS; g++) begin : g_digit
    bf_letter_digit u_digit (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_load      (w_load),
      .i_load_val  ((g == 0) ? start_offset : 5'd0),
      .i_step      ((g == 0) ? w_stride_eff : 3'd1),
      .i_carry_in  (w_carry[g]),
      .o_digit     (w_digit[g]),
      .o_carry_out (w_carry[g+1])
    );
    assign w_candidate[8*g +: 8] = digit_to_ascii(w_digit[g], w_upper);
  end

  // Search control: start/abort, handshake accounting, match and exhaustion
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cand_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_found      <= 1'b0;
      r_done       <= 1'b0;
      r_found_word <= {(8*NUM_CHARS){1'b0}};
      r_target     <= {(8*NUM_CHARS){1'b0}};
      r_attempts   <= {ATTEMPT_W{1'b0}};
    end else if (abort) begin
      r_state      <= IDLE;
      r_cand_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_found      <= 1'b0;
      r_done       <= 1'b0;
    end else if (w_start_ok) begin
      r_target   <= target;
      r_attempts <= {ATTEMPT_W{1'b0}};
      r_found    <= 1'b0;
      if (w_bad_offset) begin
        r_state      <= EXHAUSTED;
        r_done       <= 1'b1;
        r_cand_valid <= 1'b0;
        r_busy       <= 1'b0;
      end else begin
        r_state      <= RUN;
        r_done       <= 1'b0;
        r_cand_valid <= 1'b1;
        r_busy       <= 1'b1;
      end
    end else if (w_xfer) begin
      r_attempts <= w_attempts_nxt;
      if (w_match) begin
        r_state      <= FOUND;
        r_found      <= 1'b1;
        r_done       <= 1'b1;
        r_found_word <= w_candidate;
        r_cand_valid <= 1'b0;
        r_busy       <= 1'b0;
      end else if (w_exhaust) begin
        r_state      <= EXHAUSTED;
        r_done       <= 1'b1;
        r_cand_valid <= 1'b0;
        r_busy       <= 1'b0;
      end
    end
  end

  assign cand_valid = r_cand_valid;
  assign candidate  = w_candidate;
  assign busy       = r_busy;
  assign found      = r_found;
  assign done       = r_done;
  assign found_word = r_found_word;
  assign attempts   = r_attempts;

endmodule

// File: doc/brute_force_scheduler.md
Name: brute_force_scheduler

Overview:
- Sequences a NUM_CHARS-letter lowercase candidate odometer-style from a per-worker start offset and stride.
- Streams candidates out over a valid/ready handshake and compares each accepted candidate against a latched target word.
- Stops on a match or on exhaustion of the search space.
- Sits between the top-level cracker control (start/abort, target) and the candidate consumer (hash unit/UART logger). Several instances with distinct offsets share one stride to partition the keyspace.

Parameters:
- NUM_CHARS, 4, number of letters in the candidate word.
- ATTEMPT_W, 32, width of the attempt counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  pulse; begins a search when in IDLE, FOUND or EXHAUSTED.
- abort  in  1  pulse; returns to IDLE from any state.
- target  in  8*NUM_CHARS  word to find; latched on start.
- start_offset  in  5  starting/wrap index (0..25) of the rightmost letter; latched on start.
- stride  in  3  increment of the rightmost letter; latched on start; 0 treated as 1.
- cand_valid  out  1  candidate is valid.
- cand_ready  in  1  consumer accepts the candidate.
- candidate  out  8*NUM_CHARS  ASCII word; MSB byte is the leftmost letter, LSB byte is digit 0.
- busy  out  1  state is RUN.
- found  out  1  match found; sticky until start or abort.
- done  out  1  search ended (found or exhausted); sticky until start or abort.
- found_word  out  8*NUM_CHARS  matching candidate; valid while found=1.
- attempts  out  ATTEMPT_W  count of accepted candidates.

Behaviour:
- Reset values: state IDLE; cand_valid=0; candidate = all "a"; busy=0; found=0; done=0; found_word=0; attempts=0.
- States: IDLE, RUN, FOUND, EXHAUSTED.
- Letter encoding: each position is a digit 0..25; byte value = "a" + digit.
- start accepted in IDLE/FOUND/EXHAUSTED at cycle T:
  - Latch target, offset and stride. Set digit0 = offset, all other digits = 0. Clear found, done and attempts.
  - RUN at T+1 with cand_valid=1 and the first candidate.
- start with start_offset > 25: go directly to EXHAUSTED with done=1, found=0, attempts=0.
- start is ignored while in RUN.
- Handshake: a transfer happens when cand_valid && cand_ready. candidate stays stable while cand_valid=1 and cand_ready=0. attempts increments per transfer and saturates at all-ones.
- On a transfer, if candidate == target: FOUND next cycle; found=1, done=1, found_word=candidate, cand_valid=0.
- Otherwise, advance the odometer:
  - digit0 += stride.
  - If digit0 + stride > 25: digit0 <= latched offset (not 0) and carry into digit1.
  - Digits 1..NUM_CHARS-1 step by 1 on carry, wrapping 25→0 and carrying onward.
- Carry out of the top digit on a non-matching transfer: EXHAUSTED next cycle; done=1, found=0, cand_valid=0.
- abort: IDLE next cycle; cand_valid=0, busy=0, found=0, done=0. attempts and candidate are retained.
- abort has priority over start and over a same-cycle transfer (that transfer is not compared).
- Asynchronous reset mid-RUN returns everything to reset values immediately.
- Exhaustive count per worker: 26^(NUM_CHARS-1) × ceil((26 − offset)/stride).

Optional Feature:
- Macro: BRUTE_FORCE_UPPER_EN.
- Defined: adds input port upper_case (1 bit), latched on start. Letter base is "A" when upper_case=1 and "a" otherwise, for both candidate and comparison. Reset candidate is still all "a".
- Undefined: no upper_case port; base is fixed at "a".

Decomposition:
- Package bf_pkg holds: ALPHA_SIZE=26, ASCII_LOWER_A=8'h61, ASCII_UPPER_A=8'h41, and the state enum (IDLE, RUN, FOUND, EXHAUSTED).
- Sub-module bf_letter_digit: one mod-26 digit with load value, step, carry_in and carry_out, instantiated NUM_CHARS times. Digit 0 uses the stride and offset; the others use step=1 and load=0.

Test Plan (NUM_CHARS=2):
- offset=0, stride=1, target 16'h6162 ("ab"), cand_ready=1 -> candidates "aa","ab"; found=1, done=1, attempts=2, found_word=16'h6162.
- offset=0, stride=1, target 16'h0000 -> 676 transfers, last "zz"; done=1, found=0, attempts=676.
- offset=1, stride=2, target "ac" -> sequence "ab","ad",…,"az","bb",…; never found; done after attempts=338.
- Hold cand_ready=0 for 5 cycles mid-run -> candidate unchanged, attempts unchanged; resumes on release.
- abort during RUN at attempts=10 -> IDLE next cycle, cand_valid=0, busy=0, attempts=10; a following start clears attempts to 0.
- start with offset=26 -> EXHAUSTED, done=1, found=0, attempts=0. Separately, reset_n low mid-RUN -> all outputs return to reset values without a clock edge.
